// File: rtl/vid_timing_pkg.sv
// Shared video timing definitions: standard raster constants, generator state
// encoding and total-span helpers.
package vid_timing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } vt_state_t;

    // 1280x720p60
    localparam int P720_H_ACTIVE      = 1280;
    localparam int P720_H_SYNC        = 40;
    localparam int P720_H_BACK_PORCH  = 220;
    localparam int P720_H_FRONT_PORCH = 110;
    localparam int P720_V_ACTIVE      = 720;
    localparam int P720_V_SYNC        = 5;
    localparam int P720_V_BACK_PORCH  = 20;
    localparam int P720_V_FRONT_PORCH = 5;

    // 1920x1080p60
    localparam int P1080_H_ACTIVE      = 1920;
    localparam int P1080_H_SYNC        = 44;
    localparam int P1080_H_BACK_PORCH  = 148;
    localparam int P1080_H_FRONT_PORCH = 88;
    localparam int P1080_V_ACTIVE      = 1080;
    localparam int P1080_V_SYNC        = 5;
    localparam int P1080_V_BACK_PORCH  = 36;
    localparam int P1080_V_FRONT_PORCH = 4;

    function automatic int h_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int v_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/vid_span_cnt.sv
// Wrap-around span counter: counts 0..TOTAL-1 while inc is high, flags the
// terminal count, and is forced to zero by clr.
module vid_span_cnt #(
    parameter int CNT_W = 12,
    parameter int TOTAL = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vid_timing_gen.sv
// Free-running raster timing generator producing hsync/vsync/de/sof with
// frame-aligned start and graceful stop.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE      = 1280,
    parameter int H_SYNC        = 40,
    parameter int H_BACK_PORCH  = 220,
    parameter int H_FRONT_PORCH = 110,
    parameter int V_ACTIVE      = 720,
    parameter int V_SYNC        = 5,
    parameter int V_BACK_PORCH  = 20,
    parameter int V_FRONT_PORCH = 5,
    parameter bit HS_POL        = 1'b1,
    parameter bit VS_POL        = 1'b1,
    parameter int CNT_W         = 12
) (
    input  logic             pix_clk,
    input  logic             pix_rst,
    input  logic             en_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             sof_o,
    output logic [CNT_W-1:0] h_cnt_o,
    output logic [CNT_W-1:0] v_cnt_o,
    output logic             busy_o
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BACK_PORCH, H_ACTIVE, H_FRONT_PORCH);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK_PORCH, V_ACTIVE, V_FRONT_PORCH);

    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_h_total_chk
        $error("vid_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_v_total_chk
        $error("vid_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] H_DE_START = CNT_W'(H_SYNC + H_BACK_PORCH);
    localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] V_DE_START = CNT_W'(V_SYNC + V_BACK_PORCH);
    localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);

    vt_state_t        state, state_nxt;
    logic             en_q;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_tc, v_tc;
    logic             running;
    logic             frame_end;
    logic [CNT_W-1:0] h_rel, v_rel;
    logic             hs_act, vs_act, de_act, sof_act;

    assign running   = (state != IDLE);
    assign frame_end = h_tc && v_tc;

    always_ff @(posedge pix_clk or posedge pix_rst) begin
        if (pix_rst) begin
            en_q  <= 1'b0;
            state <= IDLE;
        end else begin
            en_q  <= en_i;
            state <= state_nxt;
        end
    end

    // A stop request only takes effect at the last pixel of the frame.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en_q) state_nxt = RUN;
            RUN: begin
                if (!en_q) state_nxt = frame_end ? IDLE : STOP;
            end
            STOP: begin
                if (en_q)           state_nxt = RUN;
                else if (frame_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    vid_span_cnt #(
        .CNT_W (CNT_W),
        .TOTAL (H_TOTAL)
    ) u_h_cnt (
        .clk (pix_clk),
        .rst (pix_rst),
        .clr (!running),
        .inc (running),
        .cnt (h_cnt),
        .tc  (h_tc)
    );

    vid_span_cnt #(
        .CNT_W (CNT_W),
        .TOTAL (V_TOTAL)
    ) u_v_cnt (
        .clk (pix_clk),
        .rst (pix_rst),
        .clr (!running),
        .inc (running && h_tc),
        .cnt (v_cnt),
        .tc  (v_tc)
    );

    // Offset-and-compare keeps the active window check valid even when the
    // window ends exactly at 2^CNT_W.
    always_comb begin
        h_rel   = h_cnt - H_DE_START;
        v_rel   = v_cnt - V_DE_START;
        hs_act  = running && (h_cnt < H_SYNC_C);
        vs_act  = running && (v_cnt < V_SYNC_C);
        de_act  = running && (h_rel < H_ACT_C) && (v_rel < V_ACT_C);
        sof_act = running && (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge pix_clk or posedge pix_rst) begin
        if (pix_rst) begin
            hsync_o <= ~HS_POL;
            vsync_o <= ~VS_POL;
            de_o    <= 1'b0;
            sof_o   <= 1'b0;
            h_cnt_o <= '0;
            v_cnt_o <= '0;
            busy_o  <= 1'b0;
        end else begin
            hsync_o <= hs_act ? HS_POL : ~HS_POL;
            vsync_o <= vs_act ? VS_POL : ~VS_POL;
            de_o    <= de_act;
            sof_o   <= sof_act;
            h_cnt_o <= h_cnt;
            v_cnt_o <= v_cnt;
            busy_o  <= running;
        end
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen using a small raster (14x8) and a
// cycle-level reference model feeding an expected-output scoreboard.
module tb_vid_timing_gen;

    localparam int HA = 8, HS = 2, HBP = 3, HFP = 1;
    localparam int VA = 4, VS = 1, VBP = 2, VFP = 1;
    localparam int HT = 14, VT = 8, FT = 112;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         hsync_o, vsync_o, de_o, sof_o, busy_o;
    logic [W-1:0] h_cnt_o, v_cnt_o;
    logic         hs2, vs2, de2, sof2, busy2;
    logic [W-1:0] h2, v2;

    always #5 clk = ~clk;

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_FRONT_PORCH(HFP),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(W)
    ) u_dut (
        .pix_clk(clk), .pix_rst(rst), .en_i(en),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o), .sof_o(sof_o),
        .h_cnt_o(h_cnt_o), .v_cnt_o(v_cnt_o), .busy_o(busy_o)
    );

    vid_timing_gen #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_FRONT_PORCH(HFP),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(W)
    ) u_dut_neg (
        .pix_clk(clk), .pix_rst(rst), .en_i(en),
        .hsync_o(hs2), .vsync_o(vs2), .de_o(de2), .sof_o(sof2),
        .h_cnt_o(h2), .v_cnt_o(v2), .busy_o(busy2)
    );

    typedef struct {
        logic         hs, vs, de, sof, busy;
        logic [W-1:0] h, v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: 0 = idle, 1 = run, 2 = stop
    int   m_enq, m_st, m_h, m_v;

    function automatic exp_t model_out();
        exp_t e;
        bit   on;
        on     = (m_st != 0);
        e.hs   = on && (m_h < HS);
        e.vs   = on && (m_v < VS);
        e.de   = on && (m_h >= HS + HBP) && (m_h < HS + HBP + HA)
                    && (m_v >= VS + VBP) && (m_v < VS + VBP + VA);
        e.sof  = on && (m_h == 0) && (m_v == 0);
        e.busy = on;
        e.h    = W'(m_h);
        e.v    = W'(m_v);
        return e;
    endfunction

    task automatic model_reset();
        m_enq = 0; m_st = 0; m_h = 0; m_v = 0;
        sb.delete();
    endtask

    task automatic step();
        exp_t e;
        bit   fe;
        int   nst, nh, nv;
        logic en_s;
        sb.push_back(model_out());
        fe = (m_h == HT - 1) && (m_v == VT - 1);
        if (m_enq != 0)              nst = 1;
        else if (m_st == 0 || fe)    nst = 0;
        else                         nst = 2;
        nh = m_h; nv = m_v;
        if (m_st != 0) begin
            if (m_h == HT - 1) begin
                nh = 0;
                nv = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                nh = m_h + 1;
            end
        end
        en_s = en;
        @(posedge clk);
        #1;
        m_st = nst; m_h = nh; m_v = nv; m_enq = int'(en_s);
        cyc++;
        e = sb.pop_front();
        checks++;
        if (hsync_o !== e.hs) begin failures++; $display("FAIL sb_hsync cyc=%0d got=%b exp=%b", cyc, hsync_o, e.hs); end
        checks++;
        if (vsync_o !== e.vs) begin failures++; $display("FAIL sb_vsync cyc=%0d got=%b exp=%b", cyc, vsync_o, e.vs); end
        checks++;
        if (de_o !== e.de) begin failures++; $display("FAIL sb_de cyc=%0d got=%b exp=%b", cyc, de_o, e.de); end
        checks++;
        if (sof_o !== e.sof) begin failures++; $display("FAIL sb_sof cyc=%0d got=%b exp=%b", cyc, sof_o, e.sof); end
        checks++;
        if (busy_o !== e.busy) begin failures++; $display("FAIL sb_busy cyc=%0d got=%b exp=%b", cyc, busy_o, e.busy); end
        checks++;
        if (h_cnt_o !== e.h) begin failures++; $display("FAIL sb_h_cnt cyc=%0d got=%0d exp=%0d", cyc, h_cnt_o, e.h); end
        checks++;
        if (v_cnt_o !== e.v) begin failures++; $display("FAIL sb_v_cnt cyc=%0d got=%0d exp=%0d", cyc, v_cnt_o, e.v); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({hsync_o, vsync_o, de_o, sof_o, busy_o} !== 5'b00000) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {hsync_o, vsync_o, de_o, sof_o, busy_o});
        end
        checks++;
        if (h_cnt_o !== '0 || v_cnt_o !== '0) begin
            failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", h_cnt_o, v_cnt_o);
        end
        checks++;
        if ({hs2, vs2} !== 2'b11) begin
            failures++; $display("FAIL reset_neg_pol got=%b exp=11", {hs2, vs2});
        end
        #10 rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic test_start();
        int n;
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (sof_o === 1'b1) break;
        end
        checks++;
        if (n != 3 || sof_o !== 1'b1 || hsync_o !== 1'b1) begin
            failures++; $display("FAIL start_latency got=%0d sof=%b hs=%b exp=3 1 1", n, sof_o, hsync_o);
        end
        for (int i = 0; i < 200 && de_o !== 1'b1; i++) step();
        checks++;
        if (de_o !== 1'b1 || v_cnt_o !== W'(3) || h_cnt_o !== W'(5)) begin
            failures++; $display("FAIL first_de got=de%b v%0d h%0d exp=de1 v3 h5", de_o, v_cnt_o, h_cnt_o);
        end
    endtask

    task automatic test_full_frame();
        int n_vs, n_de, n_sof, v_max;
        for (int i = 0; i < 300 && sof_o !== 1'b1; i++) step();
        checks++;
        if (sof_o !== 1'b1) begin failures++; $display("FAIL frame_sync got=%b exp=1", sof_o); end
        n_vs = 0; n_de = 0; n_sof = 0; v_max = 0;
        for (int i = 0; i < FT; i++) begin
            if (i != 0) step();
            n_vs  += int'(vsync_o === 1'b1);
            n_de  += int'(de_o === 1'b1);
            n_sof += int'(sof_o === 1'b1);
            if (int'(v_cnt_o) > v_max) v_max = int'(v_cnt_o);
        end
        checks++;
        if (n_vs != 14) begin failures++; $display("FAIL frame_vsync_len got=%0d exp=14", n_vs); end
        checks++;
        if (n_de != 32) begin failures++; $display("FAIL frame_de_len got=%0d exp=32", n_de); end
        checks++;
        if (n_sof != 1) begin failures++; $display("FAIL frame_sof_count got=%0d exp=1", n_sof); end
        checks++;
        if (v_max != 7) begin failures++; $display("FAIL frame_v_max got=%0d exp=7", v_max); end
        step();
        checks++;
        if (sof_o !== 1'b1 || v_cnt_o !== '0) begin
            failures++; $display("FAIL frame_wrap got=sof%b v%0d exp=sof1 v0", sof_o, v_cnt_o);
        end
    endtask

    task automatic test_graceful_stop();
        int  last_h, last_v, bad;
        bit  done;
        for (int i = 0; i < 300 && v_cnt_o !== W'(4); i++) step();
        en = 1'b0;
        last_h = -1; last_v = -1; done = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy_o === 1'b1) begin
                last_h = int'(h_cnt_o); last_v = int'(v_cnt_o);
            end else begin
                done = 1;
                break;
            end
            step();
        end
        checks++;
        if (!done || last_h != 13 || last_v != 7) begin
            failures++; $display("FAIL stop_last_pixel got=done%0d h%0d v%0d exp=done1 h13 v7", done, last_h, last_v);
        end
        bad = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (sof_o !== 1'b0 || de_o !== 1'b0 || hsync_o !== 1'b0 || vsync_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL stop_idle_outputs got=%0d exp=0", bad); end
    endtask

    task automatic test_stop_cancel();
        int t0, busy_low;
        en = 1'b1;
        for (int i = 0; i < 300 && sof_o !== 1'b1; i++) step();
        t0 = cyc;
        for (int i = 0; i < 30; i++) step();
        en = 1'b0;
        for (int i = 0; i < 20; i++) step();
        en = 1'b1;
        busy_low = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (busy_o !== 1'b1) busy_low++;
            if (sof_o === 1'b1) break;
        end
        checks++;
        if (sof_o !== 1'b1 || cyc - t0 != FT) begin
            failures++; $display("FAIL cancel_sof_period got=%0d exp=%0d", cyc - t0, FT);
        end
        checks++;
        if (busy_low != 0) begin failures++; $display("FAIL cancel_busy_gap got=%0d exp=0", busy_low); end
    endtask

    task automatic test_async_reset();
        int n;
        for (int i = 0; i < 300 && de_o !== 1'b1; i++) step();
        #2;
        rst = 1'b1; en = 1'b0;
        #1;
        checks++;
        if ({hsync_o, vsync_o, de_o, sof_o, busy_o} !== 5'b00000) begin
            failures++; $display("FAIL async_rst_flags got=%b exp=00000", {hsync_o, vsync_o, de_o, sof_o, busy_o});
        end
        model_reset();
        #1 rst = 1'b0;
        step();
        en = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (sof_o === 1'b1) break;
        end
        checks++;
        if (n != 3) begin failures++; $display("FAIL async_restart_latency got=%0d exp=3", n); end
    endtask

    task automatic test_polarity();
        int n_hs, n_vs;
        for (int i = 0; i < 300 && sof2 !== 1'b1; i++) step();
        n_hs = 0;
        for (int i = 0; i < 20 && hs2 === 1'b0; i++) begin
            n_hs++;
            step();
        end
        checks++;
        if (n_hs != 2) begin failures++; $display("FAIL neg_hsync_len got=%0d exp=2", n_hs); end
        for (int i = 0; i < 300 && sof2 !== 1'b1; i++) step();
        n_vs = 0;
        for (int i = 0; i < FT; i++) begin
            if (i != 0) step();
            n_vs += int'(vs2 === 1'b0);
        end
        checks++;
        if (n_vs != 14) begin failures++; $display("FAIL neg_vsync_len got=%0d exp=14", n_vs); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_full_frame();
        test_graceful_stop();
        test_stop_cancel();
        test_async_reset();
        test_polarity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
